// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parameterised synchronous FIFO with threshold flags and optional first-word-fall-through
module fifo_sync_param #(
   parameter int WordLength     = 8,
   parameter int Depth          = 16,
   parameter int AlmostFullThr  = Depth - 2,
   parameter int AlmostEmptyThr = 2,
   parameter bit Fwft           = 1'b0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_i,
   input  logic [WordLength-1:0]      w_data_i,
   input  logic                       rd_i,
   output logic [WordLength-1:0]      r_data_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       almost_empty_o,
   output logic                       almost_full_o,
   output logic [$clog2(Depth):0]     count_o,
   output logic                       overflow_o,
   output logic                       underflow_o
);

   localparam int AW = $clog2(Depth);
   localparam int CW = AW + 1;

   generate
      if (WordLength < 1 || WordLength > 64) begin : g_bad_word_length
         $error("fifo_sync_param: WordLength out of range");
      end
      if (Depth < 2 || (1 << AW) != Depth) begin : g_bad_depth
         $error("fifo_sync_param: Depth must be a power of two >= 2");
      end
      if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_bad_af
         $error("fifo_sync_param: AlmostFullThr out of range");
      end
      if (AlmostEmptyThr < 0 || AlmostEmptyThr > Depth - 1) begin : g_bad_ae
         $error("fifo_sync_param: AlmostEmptyThr out of range");
      end
   endgenerate

   logic [WordLength-1:0] mem [Depth];
   logic [AW-1:0]         wr_ptr_q;
   logic [AW-1:0]         rd_ptr_q;
   logic [CW-1:0]         count_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  rd_ok;
   logic                  wr_ok;

   // Flags come only from the registered count, never from this cycle's requests.
   assign empty_o        = (count_q == '0);
   assign full_o         = (count_q == CW'(Depth));
   assign almost_empty_o = (count_q <= CW'(AlmostEmptyThr));
   assign almost_full_o  = (count_q >= CW'(AlmostFullThr));
   assign count_o        = count_q;
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

   // A read frees the slot the write needs when full, so a full FIFO still accepts both.
   assign rd_ok = rd_i && !empty_o;
   assign wr_ok = wr_i && (!full_o || rd_ok);

   always_ff @(posedge clk_i) begin
      if (!rst_i && wr_ok) begin
         mem[wr_ptr_q] <= w_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= wr_i && !wr_ok;
         underflow_q <= rd_i && empty_o;
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (wr_ok && !rd_ok) begin
            count_q <= count_q + CW'(1);
         end else if (rd_ok && !wr_ok) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   generate
      if (Fwft) begin : g_fwft
         assign r_data_o = mem[rd_ptr_q];
      end else begin : g_registered
         logic [WordLength-1:0] r_data_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_data_q <= '0;
            end else if (rd_ok) begin
               r_data_q <= mem[rd_ptr_q];
            end
         end

         assign r_data_o = r_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed and random checks of fifo_sync_param (registered and FWFT) against a queue model
module tb_fifo_sync_param;

   localparam int WL    = 8;
   localparam int DEPTH = 4;
   localparam int AFT   = 3;
   localparam int AET   = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr  = 1'b0;
   logic          rd  = 1'b0;
   logic [WL-1:0] wdata = '0;

   logic [WL-1:0] rdata0, rdata1;
   logic          empty0, full0, ae0, af0, ov0, un0;
   logic          empty1, full1, ae1, af1, ov1, un1;
   logic [2:0]    count0, count1;

   int tests = 0;
   int fails = 0;

   logic [WL-1:0] model_q[$];
   logic [WL-1:0] exp_rdata = '0;
   logic          exp_ov = 1'b0;
   logic          exp_un = 1'b0;

   always #5 clk = ~clk;

   fifo_sync_param #(.WordLength(WL), .Depth(DEPTH), .AlmostFullThr(AFT),
                     .AlmostEmptyThr(AET), .Fwft(1'b0)) dut_reg (
      .clk_i(clk), .rst_i(rst), .wr_i(wr), .w_data_i(wdata), .rd_i(rd),
      .r_data_o(rdata0), .empty_o(empty0), .full_o(full0),
      .almost_empty_o(ae0), .almost_full_o(af0), .count_o(count0),
      .overflow_o(ov0), .underflow_o(un0)
   );

   fifo_sync_param #(.WordLength(WL), .Depth(DEPTH), .AlmostFullThr(AFT),
                     .AlmostEmptyThr(AET), .Fwft(1'b1)) dut_fwft (
      .clk_i(clk), .rst_i(rst), .wr_i(wr), .w_data_i(wdata), .rd_i(rd),
      .r_data_o(rdata1), .empty_o(empty1), .full_o(full1),
      .almost_empty_o(ae1), .almost_full_o(af1), .count_o(count1),
      .overflow_o(ov1), .underflow_o(un1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, advance the queue model, then compare both DUTs.
   task automatic cycle(input logic w, input logic r, input logic [WL-1:0] d, input logic rs);
      int  n;
      logic rd_ok, wr_ok;
      wr = w; rd = r; wdata = d; rst = rs;
      @(posedge clk);
      #1;
      n = model_q.size();
      if (rs) begin
         model_q.delete();
         exp_ov = 1'b0; exp_un = 1'b0; exp_rdata = '0;
      end else begin
         rd_ok  = r && (n > 0);
         wr_ok  = w && ((n < DEPTH) || rd_ok);
         exp_un = r && (n == 0);
         exp_ov = w && !wr_ok;
         if (rd_ok) exp_rdata = model_q.pop_front();
         if (wr_ok) model_q.push_back(d);
      end
      n = model_q.size();
      check("count_reg",  64'(count0), 64'(n));
      check("count_fwft", 64'(count1), 64'(n));
      check("empty",      {62'd0, empty0, empty1}, {62'd0, n == 0, n == 0});
      check("full",       {62'd0, full0, full1},   {62'd0, n == DEPTH, n == DEPTH});
      check("almost_empty", {62'd0, ae0, ae1},     {62'd0, n <= AET, n <= AET});
      check("almost_full",  {62'd0, af0, af1},     {62'd0, n >= AFT, n >= AFT});
      check("overflow",   {62'd0, ov0, ov1},       {62'd0, exp_ov, exp_ov});
      check("underflow",  {62'd0, un0, un1},       {62'd0, exp_un, exp_un});
      check("rdata_reg",  64'(rdata0), 64'(exp_rdata));
      if (n > 0) check("rdata_fwft", 64'(rdata1), 64'(model_q[0]));
   endtask

   initial begin
      // Reset with both requests high: ignored, no error pulse.
      cycle(1'b1, 1'b1, 8'hEE, 1'b1);
      check("reset_count", 64'(count0), 64'd0);

      // Fill and drain in order.
      cycle(1'b1, 1'b0, 8'h11, 1'b0);
      cycle(1'b1, 1'b0, 8'h22, 1'b0);
      cycle(1'b1, 1'b0, 8'h33, 1'b0);
      check("af_after_3", 64'(af0), 64'd1);
      cycle(1'b1, 1'b0, 8'h44, 1'b0);
      check("full_after_4", 64'(full0), 64'd1);
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         check("drain_value", 64'(rdata0), 64'(i * 8'h11));
      end
      check("empty_after_drain", 64'(empty0), 64'd1);

      // Overflow: rejected word never appears.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
      cycle(1'b1, 1'b0, 8'h55, 1'b0);
      check("overflow_pulse", 64'(ov0), 64'd1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      check("overflow_cleared", 64'(ov0), 64'd0);
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         check("overflow_drain", 64'(rdata0), 64'(8'hA0 + 8'(i)));
      end

      // Underflow with simultaneous write while empty.
      cycle(1'b1, 1'b1, 8'hA5, 1'b0);
      check("underflow_pulse", 64'(un0), 64'd1);
      check("underflow_count", 64'(count0), 64'd1);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("underflow_readback", 64'(rdata0), 64'hA5);

      // Full with simultaneous read and write, pointer wrap.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
      cycle(1'b1, 1'b1, 8'h05, 1'b0);
      check("simul_count", 64'(count0), 64'd4);
      check("simul_read", 64'(rdata0), 64'h01);
      for (int i = 2; i <= 5; i++) begin
         cycle(1'b0, 1'b1, 8'h00, 1'b0);
         check("simul_drain", 64'(rdata0), 64'(i));
      end

      // Reset mid-stream discards stored words.
      cycle(1'b1, 1'b0, 8'h61, 1'b0);
      cycle(1'b1, 1'b0, 8'h62, 1'b0);
      cycle(1'b1, 1'b0, 8'h99, 1'b1);
      check("midreset_count", 64'(count0), 64'd0);
      check("midreset_no_err", {62'd0, ov0, un0}, 64'd0);
      cycle(1'b1, 1'b0, 8'h77, 1'b0);
      check("fwft_77", 64'(rdata1), 64'h77);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("reg_77", 64'(rdata0), 64'h77);

      // FWFT: word visible the cycle after its write, pop empties.
      cycle(1'b1, 1'b0, 8'h3C, 1'b0);
      check("fwft_3c", 64'(rdata1), 64'h3C);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      check("fwft_pop_empty", 64'(empty1), 64'd1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         cycle(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(63) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
